// File: rtl/match_event_tracker_pkg.sv
// Shared types and constants for the match event tracker: FSM states,
// readout record layout and the run-length saturation value.
package match_evt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        ACTIVE = 2'd2
    } evt_state_t;

    localparam int DEF_TS_W  = 16;
    localparam int DEF_LEN_W = 8;
    localparam int LEN_MAX   = 2**DEF_LEN_W - 1;

    // Record as it leaves the FIFO head: start timestamp in the upper bits.
    typedef struct packed {
        logic [DEF_TS_W-1:0]  ts;
        logic [DEF_LEN_W-1:0] len;
    } evt_rec_t;

    function automatic int len_max(input int width);
        return (2**width) - 1;
    endfunction

endpackage

// File: rtl/match_event_tracker_if.sv
// Record readout port. o_valid/o_ts/o_len come from the tracker, i_ready from the consumer;
// a record transfers on any edge where o_valid & i_ready, and the head is held until then.
interface match_event_tracker_if #(
    parameter int TS_W  = 16,
    parameter int LEN_W = 8
);
    logic             o_valid;
    logic             i_ready;
    logic [TS_W-1:0]  o_ts;
    logic [LEN_W-1:0] o_len;

    modport master (output o_valid, output o_ts, output o_len, input i_ready);
    modport slave  (input o_valid, input o_ts, input o_len, output i_ready);
endinterface

// File: rtl/match_event_tracker_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_level   = r_wr - r_rd;
    // Empty head reads as zero so the readout port is quiet after reset.
    assign o_data    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/match_event_tracker.sv
// Qualifies runs of the match flag, timestamps and measures each qualified run,
// and queues {start_ts, len} records behind a valid/ready readout port.
module match_event_tracker
    import match_evt_pkg::*;
#(
    parameter int MIN_RUN = 2,
    parameter int TS_W    = 16,
    parameter int LEN_W   = 8,
    parameter int DEPTH   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_match,
    input  logic                    i_en,
    input  logic                    i_ovf_clr,
    match_event_tracker_if.master   rd,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_busy,
    output logic                    o_ovf,
    output evt_state_t              o_state
);
    localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(len_max(LEN_W));
    localparam logic [LEN_W-1:0] MIN_RUN_L = LEN_W'(MIN_RUN);

    evt_state_t       r_state, w_state_nxt;
    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_start_ts, w_start_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt, w_len_inc;
    logic             w_push, w_pop, w_full, w_empty, w_drop;
    logic [TS_W+LEN_W-1:0] w_head;

    assign w_len_inc = r_len + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_ts       <= '0;
            r_start_ts <= '0;
            r_len      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ts       <= r_ts + 1'b1;
            r_start_ts <= w_start_nxt;
            r_len      <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = r_start_ts;
        w_len_nxt   = r_len;
        w_push      = 1'b0;
        if (!i_en) begin
            w_state_nxt = IDLE;
            w_len_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_match) begin
                        w_start_nxt = r_ts;
                        w_len_nxt   = LEN_W'(1);
                        w_state_nxt = (MIN_RUN == 1) ? ACTIVE : ARMING;
                    end
                end
                ARMING: begin
                    if (i_match) begin
                        w_len_nxt = w_len_inc;
                        if (w_len_inc == MIN_RUN_L) w_state_nxt = ACTIVE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                ACTIVE: begin
                    if (i_match) begin
                        if (r_len != LEN_SAT) w_len_nxt = w_len_inc;
                    end else begin
                        // Run ends on this edge: record goes out with the length seen so far.
                        w_push      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_pop  = rd.o_valid & rd.i_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst)          o_ovf <= 1'b0;
        else if (w_drop)    o_ovf <= 1'b1;
        else if (i_ovf_clr) o_ovf <= 1'b0;
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W + LEN_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  ({r_start_ts, r_len}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    assign rd.o_valid = ~w_empty;
    assign rd.o_ts    = w_head[TS_W+LEN_W-1:LEN_W];
    assign rd.o_len   = w_head[LEN_W-1:0];
    assign o_busy     = (r_state != IDLE);
    assign o_state    = r_state;

endmodule
